// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle byte-addressed data memory with alignment check,
// load extension and a req/ready handshake with configurable wait states.
module data_mem_ctrl #(
   parameter int          ADDR_W      = 10,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] INIT_VAL    = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W+1:0] addr,
   input  logic [1:0]        size,
   input  logic              sign,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              err,
   output logic              busy
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   localparam logic [3:0] CNT_INIT = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;

   logic [31:0] mem [2**ADDR_W] = '{default: INIT_VAL};

   state_t            state, state_nx;
   logic [3:0]        cnt, cnt_nx;
   logic              err_nx, l_we, l_sign;
   logic [1:0]        l_size;
   logic [ADDR_W+1:0] l_addr;
   logic [31:0]       l_wdata;

   logic              idle, legal, acc, a_we, a_sign;
   logic [1:0]        a_size;
   logic [ADDR_W+1:0] a_addr;
   logic [31:0]       a_wdata, wd, word, ld;
   logic [15:0]       sh;
   logic [7:0]        byte_sel;
   logic [3:0]        be;

   assign idle    = state == S_IDLE;
   assign legal   = size != 2'd3 && !(size == 2'd1 && addr[0]) && !(size == 2'd2 && addr[1:0] != 2'b00);
   // In IDLE the access (zero-wait case) uses the live inputs, later it uses the latched copy
   assign a_we    = idle ? we    : l_we;
   assign a_sign  = idle ? sign  : l_sign;
   assign a_size  = idle ? size  : l_size;
   assign a_addr  = idle ? addr  : l_addr;
   assign a_wdata = idle ? wdata : l_wdata;
   assign acc     = rst_n && (idle ? req && legal && WAIT_CYCLES == 0 : state == S_WAIT && cnt == 4'd0);

   assign word     = mem[a_addr[ADDR_W+1:2]];
   assign sh       = a_addr[1] ? word[31:16] : word[15:0];
   assign byte_sel = a_addr[0] ? sh[15:8] : sh[7:0];
   assign ld = a_size == 2'd0 ? {{24{a_sign & byte_sel[7]}}, byte_sel}
             : a_size == 2'd1 ? {{16{a_sign & sh[15]}}, sh} : word;
   assign wd = a_size == 2'd0 ? {4{a_wdata[7:0]}} : a_size == 2'd1 ? {2{a_wdata[15:0]}} : a_wdata;
   assign be = a_size == 2'd0 ? 4'b0001 << a_addr[1:0]
             : a_size == 2'd1 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;

   assign ready = state == S_DONE;
   assign busy  = !idle;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      err_nx   = 1'b0;
      if (idle) begin
         if (req) begin
            state_nx = (!legal || WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
            cnt_nx   = CNT_INIT;
            err_nx   = !legal;
         end
      end else if (state == S_WAIT) begin
         state_nx = cnt == 4'd0 ? S_DONE : S_WAIT;
         cnt_nx   = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
      end else begin
         state_nx = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         err     <= 1'b0;
         rdata   <= 32'd0;
         l_we    <= 1'b0;
         l_sign  <= 1'b0;
         l_size  <= 2'd0;
         l_addr  <= '0;
         l_wdata <= 32'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         err   <= err_nx;
         if (acc && !a_we) rdata <= ld;
         if (idle && req) begin
            l_we    <= we;
            l_sign  <= sign;
            l_size  <= size;
            l_addr  <= addr;
            l_wdata <= wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (acc && a_we)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[a_addr[ADDR_W+1:2]][8*i +: 8] <= wd[8*i +: 8];
   end
endmodule
